cache_requester: RTL and testbench

CACHE_REQUESTER -- requirements
Module: cache_requester

---
 rtl/cache_requester.sv | 117 +++++++++++
 tb/tb_cache_requester.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cache_requester.sv
// Single-outstanding cache requester: latches a host command, holds the request
// until a matching response or a timeout, and reports completion with done/err.
module cache_requester #(
  parameter int unsigned PROC_ID = 0,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_store,
  input  logic [10:0] cmd_tag,
  input  logic        cmd_offset,
  input  logic [7:0]  cmd_data,
  output logic        req_valid,
  output logic [21:0] request,
  input  logic        cache_busy,
  input  logic        resp_valid,
  input  logic [21:0] data_in,
  output logic        done,
  output logic        err,
  output logic [7:0]  load_data,
  output logic [7:0]  busy_cycles
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  localparam logic       ID_BIT  = 1'(PROC_ID);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic        done_nxt, err_nxt;
  logic [7:0]  load_data_nxt, busy_nxt;
  logic        accept, match, timeout;

  logic        store_q;
  logic [10:0] tag_q;
  logic        offset_q;
  logic [7:0]  data_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign req_valid = (state == REQ);
  assign request   = (state == REQ) ? {ID_BIT, store_q, tag_q, offset_q, data_q} : 22'd0;

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    load_data_nxt = load_data;
    busy_nxt      = busy_cycles;
    accept        = 1'b0;
    match         = resp_valid && (data_in[21] == ID_BIT) &&
                    (data_in[20:8] == {store_q, tag_q, offset_q});
    timeout       = (wait_cnt == TO_LAST);
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept       = 1'b1;
          state_nxt    = REQ;
          wait_cnt_nxt = 8'd0;
        end
      end
      REQ: begin
        if (cache_busy) busy_nxt = sat_inc8(busy_cycles);
        // A match on the timeout cycle takes priority, so err stays low.
        if (match) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          if (!store_q) load_data_nxt = data_in[7:0];
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
          if (timeout) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            err_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      done        <= 1'b0;
      err         <= 1'b0;
      load_data   <= 8'd0;
      busy_cycles <= 8'd0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
      load_data   <= load_data_nxt;
      busy_cycles <= busy_nxt;
    end
  end

  // Command fields are plain data; the request output is gated by state instead.
  always_ff @(posedge clk) begin
    if (accept) begin
      store_q  <= cmd_store;
      tag_q    <= cmd_tag;
      offset_q <= cmd_offset;
      data_q   <= cmd_store ? cmd_data : 8'd0;
    end
  end

endmodule

// File: tb/tb_cache_requester.sv
// Bench for cache_requester: table of transactions with a scoreboard queue of
// expected completions, plus hand sequences for reset behaviour.
module tb_cache_requester;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_store, cmd_offset;
  logic [10:0] cmd_tag;
  logic [7:0]  cmd_data;
  logic        req_valid;
  logic [21:0] request;
  logic        cache_busy, resp_valid;
  logic [21:0] data_in;
  logic        done, err;
  logic [7:0]  load_data, busy_cycles;

  cache_requester #(.PROC_ID(0), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_tag(cmd_tag), .cmd_offset(cmd_offset), .cmd_data(cmd_data),
    .req_valid(req_valid), .request(request),
    .cache_busy(cache_busy), .resp_valid(resp_valid), .data_in(data_in),
    .done(done), .err(err), .load_data(load_data), .busy_cycles(busy_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [10:0] tag;
    logic        off;
    logic [7:0]  data;
    int          resp_at;   // REQ cycle index carrying the match, -1 for none
    int          bogus;     // 0 none, 1 wrong id, 2 wrong tag
    int          bogus_at;
    int          busy_n;    // cache_busy high for the first busy_n REQ cycles
    logic [7:0]  rdata;
    logic [21:0] exp_req;
    logic        exp_err;
    logic [7:0]  exp_ld;
    logic [7:0]  exp_busy;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    logic       err;
    logic [7:0] ld;
    logic [7:0] busy;
    int         cyc;
  } exp_t;

  vec_t vt[8];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Entered at a negedge with the DUT idle (or in its done cycle); returns at
  // the negedge where done is observed, so the next command goes back-to-back.
  task automatic run_vec(input int i);
    vec_t v;
    exp_t e;
    int   k, cyc;
    bit   got;
    v = vt[i];
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_store = v.st; cmd_tag = v.tag; cmd_offset = v.off; cmd_data = v.data;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = 8'h00;
    chk("req_valid_on", req_valid, 1'b1);
    chk("request_val", request, v.exp_req);
    chk("done_pulse_end", done, 1'b0);
    chk("err_pulse_end", err, 1'b0);
    sb.push_back('{v.exp_err, v.exp_ld, v.exp_busy, v.exp_cyc});
    k = 0; cyc = 0; got = 1'b0;
    while (!got && k < 40) begin
      if (req_valid) cyc++;
      if (request !== v.exp_req) chk("request_hold", request, v.exp_req);
      resp_valid = 1'b0; data_in = 22'd0;
      cache_busy = (k < v.busy_n);
      if (v.bogus == 1 && k == v.bogus_at) begin
        resp_valid = 1'b1; data_in = {1'b1, v.st, v.tag, v.off, v.rdata ^ 8'hFF};
      end
      if (v.bogus == 2 && k == v.bogus_at) begin
        resp_valid = 1'b1; data_in = {1'b0, v.st, v.tag ^ 11'h001, v.off, v.rdata ^ 8'hFF};
      end
      if (k == v.resp_at) begin
        resp_valid = 1'b1; data_in = {1'b0, v.st, v.tag, v.off, v.rdata};
      end
      @(negedge clk);
      k++;
      if (done) begin
        got = 1'b1;
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("err", err, e.err);
          chk("load_data", load_data, e.ld);
          chk("busy_cycles", busy_cycles, e.busy);
          chk("req_cycles", cyc, e.cyc);
          chk("req_valid_off", req_valid, 1'b0);
          chk("request_idle", request, 22'd0);
          chk("cmd_ready_done", cmd_ready, 1'b1);
        end
      end
    end
    resp_valid = 1'b0; data_in = 22'd0; cache_busy = 1'b0;
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //        st  tag     off data   at  bg bat bsy rdata  exp_req       err ld     busy cyc
    vt[0] = '{1'b0, 11'h280, 1'b0, 8'hEE, 1, 0, 0, 0, 8'h64, 22'h050000, 1'b0, 8'h64, 8'd0, 2};
    vt[1] = '{1'b1, 11'h288, 1'b1, 8'hAB, 1, 0, 0, 0, 8'hAB, 22'h1511AB, 1'b0, 8'h64, 8'd0, 2};
    vt[2] = '{1'b0, 11'h7FF, 1'b1, 8'h00, 2, 1, 0, 0, 8'h5A, 22'h0FFF00, 1'b0, 8'h5A, 8'd0, 3};
    vt[3] = '{1'b0, 11'h001, 1'b0, 8'h00, -1, 0, 0, 0, 8'h00, 22'h000200, 1'b1, 8'h5A, 8'd0, 8};
    vt[4] = '{1'b0, 11'h123, 1'b0, 8'h00, 7, 0, 0, 0, 8'hC3, 22'h024600, 1'b0, 8'hC3, 8'd0, 8};
    vt[5] = '{1'b0, 11'h055, 1'b1, 8'h77, 3, 0, 0, 3, 8'h99, 22'h00AB00, 1'b0, 8'h99, 8'd3, 4};
    vt[6] = '{1'b1, 11'h400, 1'b0, 8'h3C, 1, 2, 0, 0, 8'h3C, 22'h18003C, 1'b0, 8'h99, 8'd3, 2};
    vt[7] = '{1'b0, 11'h3FF, 1'b0, 8'h00, 1, 0, 0, 0, 8'h42, 22'h07FE00, 1'b0, 8'h42, 8'd0, 2};

    rst_n = 1'b1; cmd_valid = 1'b0; cmd_store = 1'b0; cmd_tag = 11'd0; cmd_offset = 1'b0;
    cmd_data = 8'd0; cache_busy = 1'b0; resp_valid = 1'b0; data_in = 22'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_request", request, 22'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_load_data", load_data, 8'd0);
    chk("rst_busy", busy_cycles, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Abandon a live request with reset between edges.
    cmd_valid = 1'b1; cmd_store = 1'b0; cmd_tag = 11'h0AA; cmd_offset = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_req_valid", req_valid, 1'b1);
    chk("mid_done_clr", done, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cmd_ready", cmd_ready, 1'b1);
    chk("arst_req_valid", req_valid, 1'b0);
    chk("arst_request", request, 22'd0);
    chk("arst_done", done, 1'b0);
    chk("arst_err", err, 1'b0);
    chk("arst_load_data", load_data, 8'd0);
    chk("arst_busy", busy_cycles, 8'd0);
    resp_valid = 1'b1; data_in = {1'b0, 1'b0, 11'h0AA, 1'b1, 8'h55};
    @(negedge clk);
    chk("arst_no_done", done, 1'b0);
    chk("arst_no_err", err, 1'b0);
    resp_valid = 1'b0; data_in = 22'd0;
    rst_n = 1'b1;
    run_vec(7);
    @(negedge clk);
    chk("final_done_clr", done, 1'b0);
    chk("final_err_clr", err, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
